nibble_serial_sub: RTL and testbench

//   Multi-cycle unsigned subtractor: Y = A - B - Bi over WIDTH/4 clock cycles,
//   one 4-bit slice per cycle, LSB nibble first, borrow chained between cycles.

---
 rtl/nibble_serial_sub_pkg.sv | 12 +
 rtl/nibble_serial_sub_slice.sv | 20 ++
 rtl/nibble_serial_sub.sv | 141 ++++++++++++++
 tb/tb_nibble_serial_sub.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding and slice width.
package nibble_serial_sub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_sub_slice.sv
// Combinational 4-bit subtract with borrow in/out: {bout, d} = a - b - bin.
module sub4_slice
  import nibble_serial_sub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             bin,
  output logic [NIB_W-1:0] d,
  output logic             bout
);

  logic [NIB_W:0] diff;

  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bin};
    d    = diff[NIB_W-1:0];
    bout = diff[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle unsigned subtractor Y = A - B - Bi, one nibble per cycle, LSB first,
// with valid/ready on both sides. Define SUB_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_sub
  import nibble_serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             Bo
);

  localparam int N  = WIDTH / NIB_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             brw_q, brw_d;
  logic             bo_q, bo_d;
  logic [NIB_W-1:0] nib_d;
  logic             nib_bout;
  logic [WIDTH+NIB_W-1:0] y_shift;
`ifdef SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  sub4_slice u_slice (
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0]),
    .bin  (brw_q),
    .d    (nib_d),
    .bout (nib_bout)
  );

  // Result nibbles enter at the top and shift down, so after N steps Y is aligned.
  assign y_shift = {nib_d, y_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    brw_d   = brw_q;
    bo_d    = bo_q;
`ifdef SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          brw_d   = Bi;
          cnt_d   = '0;
`ifdef SUB_OVF_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> NIB_W;
        b_d   = b_q >> NIB_W;
        brw_d = nib_bout;
        y_d   = y_shift[WIDTH+NIB_W-1:NIB_W];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          bo_d    = nib_bout;
`ifdef SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (nib_d[NIB_W-1] != a_msb_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      brw_q   <= 1'b0;
      bo_q    <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      brw_q   <= brw_d;
      bo_q    <= bo_d;
`ifdef SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Y         = y_q;
  assign Bo        = bo_q;
`ifdef SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed self-checking bench for nibble_serial_sub (WIDTH=8).
module tb_nibble_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic       Bi;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic       Bo;
`ifdef SUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_sub #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bi        (Bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
`ifdef SUB_OVF_EN
    .ovf       (ovf),
`endif
    .Bo        (Bo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set, then waits (bounded) for out_valid; reports cycles after accept.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          output int lat, output bit timed_out);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    A = a; B = b; Bi = bi; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    timed_out = 1'b0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    if (!out_valid) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Bi = 1'b0;
    step(); step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (Y !== 8'h00) begin errors++; $display("FAIL reset_Y got %h exp 00", Y); end
    checks++; if (Bo !== 1'b0) begin errors++; $display("FAIL reset_Bo got %b exp 0", Bo); end
`ifdef SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] va [5] = '{8'h5A, 8'h10, 8'h00, 8'h00, 8'h5A};
    logic [7:0] vb [5] = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'h3C};
    logic       vi [5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] ey [5] = '{8'h1E, 8'h0F, 8'hFF, 8'hFF, 8'h1D};
    logic       eb [5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    int lat; bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vi[i], lat, to);
      checks++; if (to) begin errors++; $display("FAIL basic%0d_timeout out_valid never rose", i); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic%0d_latency got %0d exp 2", i, lat); end
      checks++; if (Y !== ey[i]) begin errors++; $display("FAIL basic%0d_Y got %h exp %h", i, Y, ey[i]); end
      checks++; if (Bo !== eb[i]) begin errors++; $display("FAIL basic%0d_Bo got %b exp %b", i, Bo, eb[i]); end
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL basic%0d_return got ov=%b ir=%b exp ov=0 ir=1", i, out_valid, in_ready);
      end
      checks++; if (Y !== ey[i]) begin errors++; $display("FAIL basic%0d_Y_hold got %h exp %h", i, Y, ey[i]); end
    end
  endtask

  task automatic test_idle_hold();
    in_valid = 1'b0; A = 8'hAA; B = 8'h11;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Y !== 8'h1D || Bo !== 1'b0) begin
        errors++; $display("FAIL idle_hold got ov=%b ir=%b Y=%h Bo=%b exp ov=0 ir=1 Y=1d Bo=0", out_valid, in_ready, Y, Bo);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    out_ready = 1'b0;
    start_op(8'hC3, 8'h47, 1'b0, lat, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout out_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      A = 8'h00; B = 8'hFF; Bi = 1'b1; in_valid = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || Y !== 8'h7C || Bo !== 1'b0) begin
        errors++; $display("FAIL bp_stall%0d got ov=%b ir=%b Y=%h Bo=%b exp ov=1 ir=0 Y=7c Bo=0", i, out_valid, in_ready, Y, Bo);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    step(); step(); step();
    checks++; if (out_valid !== 1'b0 || Y !== 8'h7C) begin
      errors++; $display("FAIL bp_no_accept got ov=%b Y=%h exp ov=0 Y=7c", out_valid, Y);
    end
  endtask

  task automatic test_mid_run_reset();
    int lat; bit to;
    out_ready = 1'b1;
    A = 8'h77; B = 8'h11; Bi = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || Y !== 8'h00 || Bo !== 1'b0) begin
      errors++; $display("FAIL midrst got ir=%b ov=%b Y=%h Bo=%b exp ir=1 ov=0 Y=00 Bo=0", in_ready, out_valid, Y, Bo);
    end
    start_op(8'h03, 8'h01, 1'b0, lat, to);
    checks++; if (to || Y !== 8'h02 || Bo !== 1'b0) begin
      errors++; $display("FAIL midrst_next got to=%b Y=%h Bo=%b exp to=0 Y=02 Bo=0", to, Y, Bo);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    out_ready = 1'b1;
    start_op(8'hFF, 8'h01, 1'b0, lat, to);
    checks++; if (to || Y !== 8'hFE || Bo !== 1'b0) begin
      errors++; $display("FAIL b2b_first got to=%b Y=%h Bo=%b exp to=0 Y=fe Bo=0", to, Y, Bo);
    end
    start_op(8'h00, 8'hFF, 1'b0, lat, to);
    checks++; if (to || Y !== 8'h01 || Bo !== 1'b1) begin
      errors++; $display("FAIL b2b_second got to=%b Y=%h Bo=%b exp to=0 Y=01 Bo=1", to, Y, Bo);
    end
    step();
  endtask

`ifdef SUB_OVF_EN
  task automatic test_ovf();
    int lat; bit to;
    out_ready = 1'b1;
    start_op(8'h80, 8'h01, 1'b0, lat, to);
    checks++; if (to || Y !== 8'h7F || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_set got to=%b Y=%h ovf=%b exp to=0 Y=7f ovf=1", to, Y, ovf);
    end
    start_op(8'h05, 8'h03, 1'b0, lat, to);
    checks++; if (to || Y !== 8'h02 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got to=%b Y=%h ovf=%b exp to=0 Y=02 ovf=0", to, Y, ovf);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_idle_hold();
    test_backpressure();
    test_mid_run_reset();
    test_back_to_back();
`ifdef SUB_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
